gate_vec_seq: RTL and testbench

- Sequential stimulus-and-capture stage that sits directly upstream of the four-input gate network (inputs a,b,c,d; output e).
- On a start request it drives all 16 input combinations in binary order and holds each for a programmable number of clocks.
- In the last hold cycle of each vector it samples the network's e output into a 16-bit response word.
- Replaces hand-written delay-stepped benches with a synthesizable, self-checking sequencer.

---
 rtl/gate_vec_seq.sv | 110 +++++++++++
 tb/tb_gate_vec_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_vec_seq.sv
// Stimulus sequencer for the four-input gate network: walks all 16 vectors,
// holds each HOLD_CYCLES clocks and captures e into a response word.
module gate_vec_seq #(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] EXPECTED    = 16'hEFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        e_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t         state, state_n;
    logic [3:0]     vec_q, vec_n;
    logic [3:0]     abcd_q, abcd_n;
    logic [HW-1:0]  hold_q, hold_n;
    logic           busy_n, done_n, pass_n;
    logic [15:0]    result_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec_q  <= '0;
            abcd_q <= '0;
            hold_q <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            pass   <= 1'b0;
        end else begin
            state  <= state_n;
            vec_q  <= vec_n;
            abcd_q <= abcd_n;
            hold_q <= hold_n;
            busy   <= busy_n;
            done   <= done_n;
            result <= result_n;
            pass   <= pass_n;
        end
    end

    always_comb begin
        state_n  = state;
        vec_n    = vec_q;
        abcd_n   = abcd_q;
        hold_n   = hold_q;
        busy_n   = busy;
        done_n   = 1'b0;
        result_n = result;
        pass_n   = pass;
        unique case (state)
            IDLE: begin
                abcd_n = '0;
                if (start) begin
                    state_n  = DRIVE;
                    busy_n   = 1'b1;
                    vec_n    = '0;
                    hold_n   = '0;
                    result_n = '0;
                    pass_n   = 1'b0;
                end
            end
            DRIVE: begin
                hold_n = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    // e is combinational from the registered a..d, so it is
                    // already settled for the current vector
                    result_n[vec_q] = e_in;
                    hold_n = '0;
                    if (vec_q != 4'd15) begin
                        vec_n  = vec_q + 4'd1;
                        abcd_n = vec_q + 4'd1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = ({e_in, result[14:0]} == EXPECTED);
                        vec_n   = '0;
                        abcd_n  = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign a       = abcd_q[3];
    assign b       = abcd_q[2];
    assign c       = abcd_q[1];
    assign d       = abcd_q[0];
    assign vec_idx = vec_q;

endmodule

// File: tb/tb_gate_vec_seq.sv
// Bench for gate_vec_seq: two instances (hold 4 and hold 1) driven by a
// behavioural network model, checked against an expected response word.
module tb_gate_vec_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start4 = 1'b0;
    logic start1 = 1'b0;
    int errors = 0;
    int checks = 0;
    int emode = 0;
    logic [15:0] pat = 16'h0;
    bit use1 = 1'b0;

    always #5 clk = ~clk;

    logic a4, b4, c4, d4, busy4, done4, pass4, e4;
    logic [3:0] v4;
    logic [15:0] r4;
    logic a1, b1, c1, d1, busy1, done1, pass1, e1;
    logic [3:0] v1;
    logic [15:0] r1;

    // mode 0: correct gate network, 1: e stuck at 1, 2: random truth table
    function automatic logic net_e(int mode, logic [15:0] p, logic [3:0] i);
        logic av, bv, cv, dv;
        av = i[3];
        bv = i[2];
        cv = i[1];
        dv = i[0];
        case (mode)
            0: return !(av && bv && !cv && !dv);
            1: return 1'b1;
            default: return p[i];
        endcase
    endfunction

    function automatic logic [15:0] model_word(int mode, logic [15:0] p);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = net_e(mode, p, 4'(i));
        return w;
    endfunction

    assign e4 = net_e(emode, pat, {a4, b4, c4, d4});
    assign e1 = net_e(emode, pat, {a1, b1, c1, d1});

    gate_vec_seq #(.HOLD_CYCLES(4), .EXPECTED(16'hEFFF)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .e_in(e4),
        .a(a4), .b(b4), .c(c4), .d(d4), .vec_idx(v4),
        .busy(busy4), .done(done4), .result(r4), .pass(pass4)
    );

    gate_vec_seq #(.HOLD_CYCLES(1), .EXPECTED(16'hEFFF)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .e_in(e1),
        .a(a1), .b(b1), .c(c1), .d(d1), .vec_idx(v1),
        .busy(busy1), .done(done1), .result(r1), .pass(pass1)
    );

    logic [3:0] o_abcd, o_vec;
    logic o_busy, o_done, o_pass;
    logic [15:0] o_res;

    always_comb begin
        o_abcd = use1 ? {a1, b1, c1, d1} : {a4, b4, c4, d4};
        o_vec  = use1 ? v1 : v4;
        o_busy = use1 ? busy1 : busy4;
        o_done = use1 ? done1 : done4;
        o_pass = use1 ? pass1 : pass4;
        o_res  = use1 ? r1 : r4;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        chk({tag, " abcd"}, 32'(o_abcd), 0);
        chk({tag, " vec"}, 32'(o_vec), 0);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " done"}, 32'(o_done), 0);
        chk({tag, " result"}, 32'(o_res), 0);
        chk({tag, " pass"}, 32'(o_pass), 0);
    endtask

    // Entered 1 ns after the accepting edge; leaves in the done cycle.
    task automatic run_body(int hold, logic [15:0] exp_res);
        int n;
        logic [31:0] mask;
        for (int k = 0; k < 16 * hold; k++) begin
            n = k / hold;
            mask = (32'd1 << n) - 32'd1;
            chk("run busy", 32'(o_busy), 1);
            chk("run done", 32'(o_done), 0);
            chk("run vec", 32'(o_vec), 32'(n));
            chk("run abcd", 32'(o_abcd), 32'(n));
            chk("run pass", 32'(o_pass), 0);
            chk("run partial", 32'(o_res), 32'(exp_res) & mask);
            step();
        end
        chk("end busy", 32'(o_busy), 0);
        chk("end done", 32'(o_done), 1);
        chk("end result", 32'(o_res), 32'(exp_res));
        chk("end pass", 32'(o_pass), 32'(exp_res == 16'hEFFF));
        chk("end abcd", 32'(o_abcd), 0);
        chk("end vec", 32'(o_vec), 0);
    endtask

    task automatic pulse_start;
        if (use1) start1 = 1'b1;
        else start4 = 1'b1;
        step();
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic full_run(int hold);
        logic [15:0] w;
        w = model_word(emode, pat);
        pulse_start();
        run_body(hold, w);
        step();
        chk("post done", 32'(o_done), 0);
        chk("post result", 32'(o_res), 32'(w));
        chk("post pass", 32'(o_pass), 32'(w == 16'hEFFF));
    endtask

    initial begin
        logic [15:0] w;
        #12;
        check_zero("in reset");
        rst_n = 1'b1;
        repeat (10) begin
            step();
            check_zero("idle");
        end

        emode = 0;
        full_run(4);
        chk("gate word", 32'(o_res), 32'hEFFF);

        emode = 1;
        full_run(4);
        chk("tied word", 32'(o_res), 32'hFFFF);

        emode = 2;
        repeat (2) begin
            pat = 16'($urandom);
            full_run(4);
        end
        pat = 16'hEFFF;
        full_run(4);

        // start held high across a whole run and the done cycle
        emode = 0;
        w = model_word(emode, pat);
        start4 = 1'b1;
        step();
        run_body(4, w);
        step();
        chk("restart busy", 32'(o_busy), 1);
        chk("restart done", 32'(o_done), 0);
        chk("restart pass", 32'(o_pass), 0);
        chk("restart vec", 32'(o_vec), 0);
        chk("restart result", 32'(o_res), 0);
        start4 = 1'b0;
        run_body(4, w);
        step();

        // asynchronous reset while vector 7 is driven
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (28) step();
        chk("pre-reset vec", 32'(o_vec), 7);
        chk("pre-reset busy", 32'(o_busy), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async reset");
        #2 rst_n = 1'b1;
        step();
        check_zero("after reset");
        full_run(4);
        chk("reset rerun word", 32'(o_res), 32'hEFFF);

        use1 = 1'b1;
        emode = 0;
        full_run(1);
        chk("hold1 word", 32'(o_res), 32'hEFFF);
        emode = 2;
        pat = 16'($urandom);
        full_run(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
